// File: rtl/ram2flash_if_pkg.sv
// Shared constants for the RAM-to-flash byte streamer: FSM encoding and lane geometry.
package ram2flash_if_pkg;

    localparam int LANES      = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = LANES * BYTE_W;
    localparam int LANE_IDX_W = $clog2(LANES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_CK   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/ram2flash_if_if.sv
// Bundle of command, code-RAM read port and byte-stream signals for ram2flash_if.
interface ram2flash_if_if #(
    parameter int IMEM_WIDTH = 19
) ();

    logic                  start;
    logic [IMEM_WIDTH-1:0] base_addr;
    logic [IMEM_WIDTH:0]   word_count;
    logic                  busy;
    logic                  done;
    logic [31:0]           data_num;

    logic [IMEM_WIDTH-1:0] ram_addr;
    logic                  ram_ren;
    logic [31:0]           ram_dout;

    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    // The streamer side.
    modport master (
        input  start, base_addr, word_count, ram_dout, tx_ready,
        output busy, done, data_num, ram_addr, ram_ren, tx_data, tx_valid
    );

    // The controller / RAM / flash-writer side.
    modport slave (
        output start, base_addr, word_count, ram_dout, tx_ready,
        input  busy, done, data_num, ram_addr, ram_ren, tx_data, tx_valid
    );

endinterface

// File: rtl/ram2flash_if_ser.sv
// word2byte_ser: holds one RAM word and presents its lanes LSB-first, advancing only on an accepted byte.
module word2byte_ser
    import ram2flash_if_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              advance,
    output logic [BYTE_W-1:0] data,
    output logic              last_lane
);

    localparam logic [LANE_IDX_W-1:0] LAST_IDX = LANE_IDX_W'(LANES - 1);

    logic [WORD_W-1:0]     word_q;
    logic [LANE_IDX_W-1:0] idx;

    // NOTE: the word register is reset like any other flop; it is small and keeps tx_data at 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx    <= '0;
        end else if (load) begin
            word_q <= word;
            idx    <= '0;
        end else if (advance) begin
            idx <= idx + LANE_IDX_W'(1);
        end
    end

    // The lane only moves on a handshake, so the byte holds while the sink stalls.
    assign data      = word_q[idx*BYTE_W +: BYTE_W];
    assign last_lane = (idx == LAST_IDX);

endmodule

// File: rtl/ram2flash_if.sv
// Dumps code-RAM words as an LSB-first byte stream for the flash writer.
// Optional trailing mod-256 checksum byte when RAM2FLASH_CKSUM_EN is defined.
module ram2flash_if
    import ram2flash_if_pkg::*;
#(
    parameter int IMEM_WIDTH = 19
) (
    input logic           clk,
    input logic           rst_n,
    ram2flash_if_if.master bus
);

    localparam logic [IMEM_WIDTH:0] MAX_WORDS = {1'b1, {IMEM_WIDTH{1'b0}}};
    localparam logic [IMEM_WIDTH:0] ONE_WORD  = (IMEM_WIDTH + 1)'(1);
`ifdef RAM2FLASH_CKSUM_EN
    localparam state_t TAIL_STATE = S_CK;
`else
    localparam state_t TAIL_STATE = S_FIN;
`endif

    state_t                state_q, state_d;
    logic [IMEM_WIDTH-1:0] word_addr;
    logic [IMEM_WIDTH:0]   words_left;
    logic [31:0]           data_num;
    logic                  done_q;

    logic              ram_ren, tx_valid, load;
    logic              accept, hs, byte_hs, word_hs, last_lane, last_word;
    logic [BYTE_W-1:0] ser_data, tx_data;

    word2byte_ser u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .word      (bus.ram_dout),
        .advance   (byte_hs),
        .data      (ser_data),
        .last_lane (last_lane)
    );

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign hs        = tx_valid && bus.tx_ready;
    assign byte_hs   = (state_q == S_SEND) && bus.tx_ready;
    assign word_hs   = byte_hs && last_lane;
    assign last_word = (words_left == ONE_WORD);

    // NOTE: state and counters use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        ram_ren  = 1'b0;
        tx_valid = 1'b0;
        load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = (bus.word_count == '0) ? TAIL_STATE : S_RD;
            end
            S_RD: begin
                ram_ren = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                load    = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (word_hs) state_d = last_word ? TAIL_STATE : S_RD;
            end
`ifdef RAM2FLASH_CKSUM_EN
            S_CK: begin
                tx_valid = 1'b1;
                if (bus.tx_ready) state_d = S_FIN;
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef RAM2FLASH_CKSUM_EN
    logic [BYTE_W-1:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sum <= '0;
        else if (accept)  sum <= '0;
        else if (byte_hs) sum <= sum + ser_data;
    end

    assign tx_data = (state_q == S_CK) ? sum : ser_data;
`else
    assign tx_data = ser_data;
`endif

    // word_addr doubles as ram_addr: it moves only as RD is entered, so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_addr  <= '0;
            words_left <= '0;
            data_num   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == S_FIN);
            if (accept) begin
                data_num   <= '0;
                words_left <= (bus.word_count > MAX_WORDS) ? MAX_WORDS : bus.word_count;
                if (bus.word_count != '0) word_addr <= bus.base_addr;
            end else begin
                if (hs) data_num <= data_num + 32'd1;
                if (word_hs) begin
                    words_left <= words_left - ONE_WORD;
                    if (!last_word) word_addr <= word_addr + IMEM_WIDTH'(1);
                end
            end
        end
    end

    assign bus.ram_addr = word_addr;
    assign bus.ram_ren  = ram_ren;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.data_num = data_num;

endmodule

// File: tb/tb_ram2flash_if.sv
// Scoreboard bench for ram2flash_if: a byte/address model feeds queues that a negedge monitor drains.
module tb_ram2flash_if;

    localparam int AW = 19;
`ifdef RAM2FLASH_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk;
    logic rst_n;

    ram2flash_if_if #(.IMEM_WIDTH(AW)) bus ();

    ram2flash_if #(.IMEM_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]   ram [int];
    logic [7:0]    exp_bytes [$];
    logic [AW-1:0] exp_addr [$];

    int         rdy_mode = 0;
    int         cyc = 0;
    int         first_valid = -1;
    logic       stalled = 1'b0;
    logic [7:0] stall_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: activity seen with nothing expected", name);
    endtask

    function automatic logic [31:0] ram_rd(input logic [AW-1:0] a);
        if (!ram.exists(int'(a))) ram[int'(a)] = $urandom;
        return ram[int'(a)];
    endfunction

    // Synchronous-read RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.ram_ren) bus.ram_dout <= ram_rd(bus.ram_addr);
    end

    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ~bus.tx_ready;
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every RAM read and every accepted byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled) begin
                check("stall_valid", 32'(bus.tx_valid), 32'd1);
                check("stall_data", 32'(bus.tx_data), 32'(stall_data));
            end
            if (bus.ram_ren) begin
                if (exp_addr.size() == 0) unexpected("ram_ren");
                else check("ram_addr", 32'(bus.ram_addr), 32'(exp_addr.pop_front()));
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_bytes.size() == 0) unexpected("tx_byte");
                else check("tx_byte", 32'(bus.tx_data), 32'(exp_bytes.pop_front()));
            end
            if (bus.tx_valid && first_valid < 0) first_valid = cyc;
            stalled    = bus.tx_valid && !bus.tx_ready;
            stall_data = bus.tx_data;
        end else begin
            stalled = 1'b0;
        end
    end

    // Model: expected addresses and bytes straight from the RAM contents; returns the byte total.
    task automatic expect_xfer(input logic [AW-1:0] base, input int n, output int nb);
        logic [AW-1:0] a;
        logic [31:0]   w;
        logic [7:0]    sum;
        sum = '0;
        nb  = 0;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            w = ram_rd(a);
            for (int l = 0; l < 4; l++) begin
                exp_bytes.push_back(w[8*l +: 8]);
                sum = sum + w[8*l +: 8];
                nb++;
            end
        end
        if (CK != 0) begin
            exp_bytes.push_back(sum);
            nb++;
        end
    endtask

    task automatic issue_start(input logic [AW-1:0] base, input int n);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = (AW + 1)'(n);
        first_valid    = -1;
        cyc            = 0;
        @(posedge clk);
        #1;
        bus.base_addr  = AW'($urandom);
        bus.word_count = (AW + 1)'($urandom_range(0, 7));
        cyc            = 1;
    endtask

    task automatic run_xfer(input logic [AW-1:0] base, input int n, input int mode, input bit poke);
        int nb;
        int done_cyc;
        int fin_cyc;
        int exp_fv;
        rdy_mode = mode;
        expect_xfer(base, n, nb);
        fin_cyc = 6 * n + 1 + CK;
        issue_start(base, n);
        bus.start = poke && mode == 0 && fin_cyc == 1;
        done_cyc  = -1;
        while (cyc < 2000) begin
            @(negedge clk);
            if (cyc == 1) check("busy_after_start", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            bus.start = poke && (cyc == 3 || (mode == 0 && cyc == fin_cyc));
        end
        bus.start = 1'b0;
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within 2000 cycles (base=%h n=%0d)", base, n);
        end else if (mode == 0) begin
            check("done_cycle", 32'(done_cyc), 32'(6 * n + 2 + CK));
        end
        exp_fv = (n > 0) ? 3 : ((CK != 0) ? 1 : -1);
        check("first_valid_cycle", 32'(first_valid), 32'(exp_fv));
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("data_num", bus.data_num, 32'(nb));
        check("bytes_outstanding", 32'(exp_bytes.size()), 32'd0);
        check("reads_outstanding", 32'(exp_addr.size()), 32'd0);
        exp_bytes.delete();
        exp_addr.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_ram_ren"}, 32'(bus.ram_ren), 32'd0);
        check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
        check({tag, "_data_num"}, bus.data_num, 32'd0);
    endtask

    // Abort a 2-word transfer right after its fifth accepted byte, then rerun it.
    task automatic reset_abort(input logic [AW-1:0] base);
        int nb;
        rdy_mode = 0;
        expect_xfer(base, 2, nb);
        issue_start(base, 2);
        bus.start = 1'b0;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bytes_before_abort", 32'(exp_bytes.size()), 32'(nb - 5));
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_bytes.delete();
        exp_addr.delete();
        repeat (2) begin
            @(negedge clk);
            check("no_done_in_reset", 32'(bus.done), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("no_done_after_abort", 32'(bus.done), 32'd0);
        run_xfer(base, 2, 0, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] base;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        ram[32'h10]    = 32'h4433_2211;
        ram[32'h11]    = 32'h8877_6655;
        ram[32'h7FFFF] = 32'hDEAD_BEEF;
        ram[32'h0]     = 32'h0BAD_F00D;
        ram[32'h20]    = 32'h0403_0201;
        ram[32'h21]    = 32'h0807_0605;

        run_xfer(AW'(32'h10), 2, 0, 1'b1);
        run_xfer(AW'(32'h10), 2, 1, 1'b0);
        run_xfer(AW'(32'h10), 0, 0, 1'b1);
        run_xfer(AW'(32'h7FFFF), 2, 2, 1'b0);
        run_xfer(AW'(32'h20), 2, 0, 1'b1);
        reset_abort(AW'(32'h40));

        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 1) == 1) base = AW'($urandom);
            else base = AW'(32'h7FFFF - $urandom_range(0, 3));
            run_xfer(base, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
